// File: rtl/spart_program_buffer.sv
// rtl/spart_program_buffer.sv - assembles a framed UART byte stream into a word RAM and serves halt-padded reads
module spart_program_buffer #(
    parameter int          DEPTH     = 1024,
    parameter int          ADDR_W    = 10,
    parameter logic [15:0] FILL_WORD = 16'hF800
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    input  logic              clr_i,
    input  logic [15:0]       r_addr_i,
    output logic [15:0]       rd_data_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              busy_o,
    output logic              load_done_o,
    output logic              load_err_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    logic [2:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic              phase_q, phase_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              busy_q, load_done_q, load_err_q;
    logic [15:0]       rd_data_q, rd_data_d;

    logic [15:0]       mem [DEPTH];
    logic              wr_en;
    logic [15:0]       wr_data;
    logic [15:0]       len_rx;
    logic [ADDR_W:0]   wr_ptr_inc;
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_oob;
    logic              unused_addr_lsb;

    assign len_rx     = {hi_q, rx_data_i};
    assign wr_data    = {hi_q, rx_data_i};
    assign wr_ptr_inc = wr_ptr_q + (ADDR_W+1)'(1);

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        hi_d         = hi_q;
        phase_d      = phase_q;
        wr_ptr_d     = wr_ptr_q;
        word_count_d = word_count_q;
        wr_en        = 1'b0;
        // clr wins over a byte arriving in the same cycle; that byte is dropped
        if (clr_i) begin
            state_d      = S_IDLE;
            phase_d      = 1'b0;
            wr_ptr_d     = '0;
            word_count_d = '0;
        end else if (rx_valid_i) begin
            case (state_q)
                S_IDLE: begin
                    hi_d    = rx_data_i;
                    state_d = S_LEN_LO;
                end
                S_LEN_LO: begin
                    len_d = len_rx;
                    if (len_rx == 16'd0) begin
                        state_d = S_DONE;
                    end else if (len_rx > DEPTH_W) begin
                        state_d = S_ERR;
                    end else begin
                        state_d  = S_DATA;
                        wr_ptr_d = '0;
                        phase_d  = 1'b0;
                    end
                end
                S_DATA: begin
                    if (!phase_q) begin
                        hi_d    = rx_data_i;
                        phase_d = 1'b1;
                    end else begin
                        wr_en        = 1'b1;
                        wr_ptr_d     = wr_ptr_inc;
                        word_count_d = wr_ptr_inc;
                        phase_d      = 1'b0;
                        if ({{(15-ADDR_W){1'b0}}, wr_ptr_inc} == len_q) begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Anything at or beyond the committed count reads as HALT, which also
    // covers a read racing the write of the same word
    assign rd_idx          = r_addr_i[ADDR_W:1];
    assign rd_oob          = |r_addr_i[15:ADDR_W+1];
    assign unused_addr_lsb = r_addr_i[0];

    always_comb begin
        rd_data_d = mem[rd_idx];
        if (rd_oob || ({1'b0, rd_idx} >= word_count_q)) begin
            rd_data_d = FILL_WORD;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            hi_q         <= '0;
            phase_q      <= 1'b0;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            rd_data_q    <= 16'h0000;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            hi_q         <= hi_d;
            phase_q      <= phase_d;
            wr_ptr_q     <= wr_ptr_d;
            word_count_q <= word_count_d;
            busy_q       <= (state_d == S_LEN_LO) || (state_d == S_DATA);
            load_done_q  <= (state_d == S_DONE);
            load_err_q   <= (state_d == S_ERR);
            rd_data_q    <= rd_data_d;
        end
    end

    assign rd_data_o    = rd_data_q;
    assign word_count_o = word_count_q;
    assign busy_o       = busy_q;
    assign load_done_o  = load_done_q;
    assign load_err_o   = load_err_q;

endmodule

// File: tb/tb_spart_program_buffer.sv
// tb/tb_spart_program_buffer.sv - randomized self-checking bench for spart_program_buffer
module tb_spart_program_buffer;

    localparam int          DEPTH  = 1024;
    localparam int          ADDR_W = 10;
    localparam logic [15:0] FILL   = 16'hF800;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_valid = 1'b0;
    logic            clr = 1'b0;
    logic [15:0]     r_addr = 16'h0000;
    logic [15:0]     rd_data;
    logic [ADDR_W:0] word_count;
    logic            busy;
    logic            load_done;
    logic            load_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: the bytes of the current frame since the last clr/reset
    logic [7:0] fb[$];

    spart_program_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .FILL_WORD(FILL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data_i    (rx_data),
        .rx_valid_i   (rx_valid),
        .clr_i        (clr),
        .r_addr_i     (r_addr),
        .rd_data_o    (rd_data),
        .word_count_o (word_count),
        .busy_o       (busy),
        .load_done_o  (load_done),
        .load_err_o   (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int m_len();
        return (fb.size() >= 2) ? int'({fb[0], fb[1]}) : -1;
    endfunction

    function automatic bit m_err();
        return (fb.size() >= 2) && (m_len() > DEPTH);
    endfunction

    function automatic int m_words();
        if (fb.size() < 2 || m_err()) return 0;
        return (fb.size() - 2) / 2;
    endfunction

    function automatic bit m_done();
        return (fb.size() >= 2) && !m_err() && (m_words() == m_len());
    endfunction

    function automatic bit m_busy();
        return (fb.size() == 1) || ((fb.size() >= 2) && !m_done() && !m_err());
    endfunction

    function automatic logic [15:0] m_read(input logic [15:0] a);
        int idx;
        idx = int'(a[ADDR_W:1]);
        if (a[15:ADDR_W+1] != 0 || idx >= m_words()) return FILL;
        return {fb[2 + 2*idx], fb[3 + 2*idx]};
    endfunction

    task automatic check_all(input logic [15:0] exp_rd);
        chk("rd_data", 32'(rd_data), 32'(exp_rd));
        chk("word_count", 32'(word_count), 32'(m_words()));
        chk("busy", 32'(busy), 32'(m_busy()));
        chk("load_done", 32'(load_done), 32'(m_done()));
        chk("load_err", 32'(load_err), 32'(m_err()));
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic c, input logic [15:0] a);
        logic [15:0] exp_rd;
        rx_valid = v;
        rx_data  = d;
        clr      = c;
        r_addr   = a;
        exp_rd   = m_read(a);
        @(posedge clk);
        if (c) fb.delete();
        else if (v && !m_done() && !m_err()) fb.push_back(d);
        #1;
        rx_valid = 1'b0;
        clr      = 1'b0;
        check_all(exp_rd);
    endtask

    task automatic send(input logic [7:0] d, input logic [15:0] a);
        step(1'b1, d, 1'b0, a);
    endtask

    task automatic idle(input logic [15:0] a);
        step(1'b0, 8'h00, 1'b0, a);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        fb.delete();
        check_all(16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] rand_addr(input int span);
        if ($urandom_range(0, 7) == 0) return 16'($urandom);
        return 16'($urandom_range(0, span));
    endfunction

    initial begin
        do_reset();

        // Basic 3-word frame
        begin
            logic [7:0] f1[8];
            f1 = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hF8, 8'h00};
            foreach (f1[i]) send(f1[i], 16'h0000);
        end
        idle(16'h0000);
        idle(16'h0002);
        idle(16'h0004);
        idle(16'h0006);
        idle(16'h0006);

        // Zero-length frame
        step(1'b0, 8'h00, 1'b1, 16'h0000);
        send(8'h00, 16'h0000);
        send(8'h00, 16'h0000);
        idle(16'h0000);
        idle(16'h0002);

        // Oversized frame, then clr and a fresh 1-word frame
        step(1'b0, 8'h00, 1'b1, 16'h0000);
        send(8'h04, 16'h0000);
        send(8'h01, 16'h0000);
        for (int i = 0; i < 10; i++) send(8'($urandom), 16'h0000);
        step(1'b0, 8'h00, 1'b1, 16'h0000);
        send(8'h00, 16'h0000);
        send(8'h01, 16'h0000);
        send(8'h9A, 16'h0000);
        send(8'hBC, 16'h0000);
        idle(16'h0000);
        idle(16'h0000);

        // Reset mid-frame, then reload
        step(1'b0, 8'h00, 1'b1, 16'h0000);
        send(8'h00, 16'h0000);
        send(8'h02, 16'h0000);
        send(8'h11, 16'h0000);
        send(8'h22, 16'h0000);
        send(8'h33, 16'h0000);
        do_reset();
        idle(16'h0000);
        idle(16'h0000);
        send(8'h00, 16'h0000);
        send(8'h01, 16'h0000);
        send(8'h55, 16'h0000);
        send(8'h66, 16'h0000);
        idle(16'h0000);
        idle(16'h0000);

        // clr colliding with the second data byte
        step(1'b0, 8'h00, 1'b1, 16'h0000);
        send(8'h00, 16'h0000);
        send(8'h02, 16'h0000);
        send(8'hAA, 16'h0000);
        step(1'b1, 8'hBB, 1'b1, 16'h0000);
        idle(16'h0800);
        idle(16'h0800);

        // Read racing the write of the same word
        send(8'h00, 16'h0002);
        send(8'h02, 16'h0002);
        send(8'h12, 16'h0002);
        send(8'h34, 16'h0002);
        send(8'hBE, 16'h0002);
        send(8'hEF, 16'h0002);
        idle(16'h0002);
        idle(16'h0002);

        // Max-size frame with random gaps and reads
        step(1'b0, 8'h00, 1'b1, 16'h0000);
        send(8'h04, 16'h0000);
        send(8'h00, 16'h0000);
        for (int i = 0; i < 2*DEPTH; i++) begin
            if ($urandom_range(0, 3) == 0) idle(rand_addr(2100));
            send(8'($urandom), rand_addr(2100));
        end
        idle(16'h07FE);
        idle(16'h07FF);
        idle(16'h0800);
        idle(16'h0000);

        // Random short frames with occasional clr, oversize lengths and resets
        for (int it = 0; it < 40; it++) begin
            int len;
            int nbytes;
            step(1'b0, 8'h00, 1'b1, 16'h0000);
            case ($urandom_range(0, 9))
                0:       len = $urandom_range(DEPTH + 1, 65535);
                1:       len = 0;
                default: len = $urandom_range(1, 8);
            endcase
            nbytes = 2 + ((len <= DEPTH) ? 2*len : 6) + $urandom_range(0, 3);
            for (int b = 0; b < nbytes; b++) begin
                logic [7:0] d;
                if (b == 0)      d = 8'(len >> 8);
                else if (b == 1) d = 8'(len);
                else             d = 8'($urandom);
                if ($urandom_range(0, 2) == 0) idle(rand_addr(20));
                if ($urandom_range(0, 60) == 0) step(1'($urandom), d, 1'b1, rand_addr(20));
                else send(d, rand_addr(20));
            end
            for (int k = 0; k < 4; k++) idle(rand_addr(20));
            if ($urandom_range(0, 9) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spart_program_buffer.md
Name: spart_program_buffer

Overview:
Upstream stage of the SPART program-load path. Receives a framed byte stream from the SPART UART receiver and assembles it into 16-bit words. Stores the words in an internal word RAM. Serves the byte-addressed read port that the SPART control block walks (r_addr in steps of 2, data sampled a few cycles later), and returns a HALT opcode for any address past the loaded image so the downstream control stops cleanly.

Parameters:
DEPTH, 1024, word capacity of the internal RAM.
ADDR_W, 10, word-index width; must equal log2(DEPTH).
FILL_WORD, 16'hF800, value returned for unloaded or out-of-range reads (opcode 11111 = HALT).

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
rx_data  input  8  received byte from the UART receiver
rx_valid  input  1  single-cycle strobe; rx_data is valid in that cycle; always accepted
clr  input  1  synchronous restart of loading; discards the current image
r_addr  input  16  byte read address from the SPART control block
rd_data  output  16  registered read data
word_count  output  ADDR_W+1  number of words committed so far
busy  output  1  high while a frame is in progress (states LEN_LO and DATA)
load_done  output  1  high once the full frame is stored; held high
load_err  output  1  sticky; set when the frame length exceeds DEPTH

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; word_count, wr_ptr, len, byte phase all 0.
  - busy, load_done, load_err = 0; rd_data = 16'h0000.
  - RAM contents are not reset.
- Frame format: LEN_HI, LEN_LO, then len words, each sent high byte first. len is 16 bits, unsigned.
- FSM states: IDLE, LEN_LO, DATA, DONE, ERR. All transitions occur only on rx_valid, except clr.
  - IDLE: on rx_valid, latch the byte as len[15:8] and go to LEN_LO.
  - LEN_LO: on rx_valid, form len = {hi, byte}.
    - len == 0: go to DONE.
    - len > DEPTH: go to ERR.
    - otherwise: go to DATA with wr_ptr = 0 and phase = 0.
  - DATA, phase 0: on rx_valid, latch the byte as the high byte; phase = 1.
  - DATA, phase 1: on rx_valid, write mem[wr_ptr] = {hi, byte}; wr_ptr++; word_count = wr_ptr+1 in the same edge; phase = 0. If wr_ptr+1 == len, go to DONE.
  - DONE: load_done = 1 from the edge that enters DONE; rx_valid ignored.
  - ERR: load_err = 1 from the edge that enters ERR; rx_valid ignored; no RAM writes.
- clr, any state:
  - Go to IDLE; word_count, wr_ptr, phase, load_done, load_err all = 0.
  - clr has priority over rx_valid in the same cycle (that byte is dropped).
- busy is a registered decode: 1 in LEN_LO and DATA, else 0.
- Read port (1-cycle latency): rd_data at edge t+1 reflects r_addr at edge t.
  - index = r_addr[ADDR_W:1]; r_addr[0] is ignored.
  - If r_addr[15:ADDR_W+1] != 0, or index >= word_count (value before this edge's update), rd_data = FILL_WORD.
  - Otherwise rd_data = mem[index].
- Read/write to the same index in the same cycle: that read returns FILL_WORD; the next read returns the new word.
- word_count never exceeds DEPTH. The max-size frame (len == DEPTH) fills the RAM exactly and reaches DONE.
- Reset mid-frame: everything returns to reset values immediately; the partial image is invisible because word_count = 0.

Test Plan:
- Bytes 00 03 12 34 AB CD F8 00 -> word_count 1,2,3 after each word; load_done rises the edge after byte 8; r_addr 0/2/4 -> rd_data 1234/ABCD/F800 one cycle later; r_addr 6 -> F800.
- Frame with len 00 00 -> DONE after the second byte, word_count 0, busy never high in DATA; every read returns F800.
- Frame with len 04 01 (1025 > DEPTH) -> load_err = 1 and stays set; 10 further bytes cause no writes; clr -> load_err 0, state IDLE, and a fresh 1-word frame loads correctly.
- Frame len 00 02, send 11 22 33; assert rst_n low -> busy 0, word_count 0, r_addr 0 -> F800. Reload 00 01 55 66 -> r_addr 0 -> 5566.
- Frame len 00 02: pulse clr in the same cycle as the 2nd data byte -> byte dropped, state IDLE, word_count 0. Then r_addr 16'h0800 (index beyond range) -> F800.
- Hold r_addr 2 while word 1 (BEEF) commits -> rd_data F800 in the write cycle, BEEF the following cycle. Full 1024-word frame -> word_count 1024, load_done 1, r_addr 16'h07FE returns the last word.
